// File: rtl/timeout_counter_if.sv
// Control/status bundle between the game FSM and a timeout_counter instance.
interface timeout_counter_if #(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned PRESCALE_W = 8
) ();
  logic                  E;
  logic                  RESTART;
  logic                  MODE;
  logic [SIZE-1:0]       LIMIT;
  logic [PRESCALE_W-1:0] PRESC;
  logic [SIZE-1:0]       TEMPO;
  logic                  end_time;
  logic                  expired;

  modport master (
    output E, RESTART, MODE, LIMIT, PRESC,
    input  TEMPO, end_time, expired
  );

  modport slave (
    input  E, RESTART, MODE, LIMIT, PRESC,
    output TEMPO, end_time, expired
  );
endinterface

// File: rtl/timeout_counter.sv
// Prescaled up-counter to a live LIMIT with a one-cycle end_time pulse;
// either reloads to zero or stops with a sticky expired flag.
module timeout_counter #(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic              CLKT,
  input  logic              R,
  timeout_counter_if.slave  bus
);

  logic [PRESCALE_W-1:0] r_presc;
  logic [SIZE-1:0]       r_tempo;
  logic                  r_end_time;
  logic                  r_expired;

  logic                  w_active;
  logic                  w_tick;
  logic                  w_terminal;
  logic [PRESCALE_W-1:0] w_presc_nxt;
  logic [SIZE-1:0]       w_tempo_nxt;
  logic                  w_end_time_nxt;
  logic                  w_expired_nxt;

  // >= comparisons let a lowered PRESC or LIMIT take effect on the next tick
  always_comb begin
    w_active       = bus.E && !r_expired;
    w_tick         = w_active && (r_presc >= bus.PRESC);
    w_terminal     = w_tick && (r_tempo >= bus.LIMIT);
    w_presc_nxt    = r_presc;
    w_tempo_nxt    = r_tempo;
    w_end_time_nxt = 1'b0;
    w_expired_nxt  = r_expired;

    if (w_active) begin
      if (w_tick) begin
        w_presc_nxt = '0;
        if (w_terminal) begin
          w_end_time_nxt = 1'b1;
          if (bus.MODE) begin
            w_tempo_nxt = '0;
          end else begin
            w_tempo_nxt   = bus.LIMIT;
            w_expired_nxt = 1'b1;
          end
        end else begin
          w_tempo_nxt = r_tempo + SIZE'(1);
        end
      end else begin
        w_presc_nxt = r_presc + PRESCALE_W'(1);
      end
    end
  end

  // Reset outranks RESTART; both clear the same state
  always_ff @(posedge CLKT) begin
    if (R || bus.RESTART) begin
      r_presc    <= '0;
      r_tempo    <= '0;
      r_end_time <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_tempo    <= w_tempo_nxt;
      r_end_time <= w_end_time_nxt;
      r_expired  <= w_expired_nxt;
    end
  end

  assign bus.TEMPO    = r_tempo;
  assign bus.end_time = r_end_time;
  assign bus.expired  = r_expired;

endmodule

// File: doc/timeout_counter.md
Name: timeout_counter

Overview:
- Parametrised successor to the game's round-timer counter.
- Counts prescaled ticks from 0 up to a runtime-programmable LIMIT.
- At LIMIT it raises a one-cycle end_time pulse, then either reloads (auto-reload mode) or stops with a sticky expired flag (one-shot mode).
- Used by the game FSM for player-response timeouts and sequence-display pacing.

Parameters:
- SIZE, 4, width of TEMPO and LIMIT.
- PRESCALE_W, 8, width of PRESC and the internal prescaler counter.

Ports:
- CLKT  in  1  system clock, rising edge.
- R  in  1  synchronous, active-high reset.
- E  in  1  count enable; when low, prescaler and TEMPO freeze.
- RESTART  in  1  synchronous re-arm: clears count, prescaler and expired.
- MODE  in  1  0 = one-shot, 1 = auto-reload; sampled live.
- LIMIT  in  SIZE  terminal count; sampled live.
- PRESC  in  PRESCALE_W  tick divisor; one tick every PRESC+1 enabled clocks.
- TEMPO  out  SIZE  current count.
- end_time  out  1  one-cycle pulse on the terminal tick.
- expired  out  1  sticky flag, one-shot mode only.

Behaviour:
- All state updates on the rising edge of CLKT; no asynchronous paths.
- Priority per edge: R > RESTART > E.
- Reset (R=1): TEMPO=0, prescaler=0, end_time=0, expired=0.
- RESTART=1 (with R=0): same clears as reset. Takes effect regardless of E.
- end_time is registered and is 0 on every cycle that is not a terminal tick. It is never high two consecutive cycles unless LIMIT=0 and PRESC=0.
- E=0: prescaler, TEMPO and expired hold; end_time=0.
- expired=1 (with E=1): counter is frozen as in E=0; no further ticks, no end_time.
- Prescaler, E=1 and expired=0:
  - If prescaler==PRESC: a tick occurs and the prescaler goes to 0.
  - Otherwise the prescaler increments.
  - PRESC=0 gives a tick every enabled clock.
  - If PRESC is lowered below the current prescaler value, the tick fires on the next enabled clock (comparison is >=).
- On a tick, the terminal condition is TEMPO >= LIMIT. The >= handles LIMIT lowered mid-count.
- Non-terminal tick: TEMPO <= TEMPO+1; end_time=0.
- Terminal tick, MODE=1: TEMPO <= 0; end_time=1.
- Terminal tick, MODE=0: TEMPO <= LIMIT (clamped); end_time=1; expired <= 1.
- Period in auto-reload mode: (LIMIT+1)*(PRESC+1) enabled clocks between end_time pulses.
- LIMIT=0: every tick is terminal; TEMPO stays 0.
- LIMIT = 2^SIZE-1: TEMPO reaches all-ones, then terminates; there is never an arithmetic wrap past all-ones.
- MODE change mid-count affects only the next terminal tick.
- Switching MODE 0->1 while expired=1 does not clear expired; only RESTART or R clears it.
- Latency: end_time asserts the cycle after the edge that observes the terminal tick (registered output). TEMPO reflects the post-edge value.
- Complete implementation: prescaler counter, TEMPO counter, two flag registers, comparators. No multi-driven registers.

Test Plan:
- Auto-reload (SIZE=4, LIMIT=9, PRESC=0, MODE=1), E=1 after R -> TEMPO steps 1..9. The 10th edge gives TEMPO=0 and end_time=1 for exactly one cycle, repeating every 10 clocks over 3 periods.
- Prescaler (LIMIT=3, PRESC=2, MODE=1) -> TEMPO increments every 3rd clock; end_time pulses every 12 clocks. Dropping E for 5 clocks mid-count shifts the next pulse by exactly 5 clocks, with TEMPO and the prescaler frozen.
- One-shot (LIMIT=5, PRESC=0, MODE=0) -> single end_time pulse on the 6th edge, then expired=1 and TEMPO holds 5 for 20 more clocks with E=1 and no pulses. RESTART=1 for one cycle gives TEMPO=0, expired=0, and counting resumes.
- Boundaries:
  - LIMIT=15 -> TEMPO reaches 15, then 0 with a pulse, no overflow glitch.
  - LIMIT=0 -> end_time high every enabled clock, TEMPO=0.
  - TEMPO=7 when LIMIT is changed to 4 -> next tick is terminal, end_time=1, TEMPO=0.
- Reset and priority:
  - R=1 at TEMPO=6 with E=1 -> all outputs 0 on the next edge.
  - R and RESTART both high -> reset values.
  - RESTART coincident with a terminal tick -> TEMPO=0, end_time=0, expired=0.
